// File: rtl/mem_arbiter_if.sv
// Bus bundle between mem_arbiter, fetch/data requesters and memory.
// slave = arbiter view, master = requester/memory side view.
interface mem_arbiter_if #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 32
);
  logic                 if_req_i;
  logic [ADDRWIDTH-1:0] if_addr_i;
  logic                 if_gnt_o;
  logic                 if_rvalid_o;
  logic [DATAWIDTH-1:0] if_rdata_o;
  logic                 dm_req_i;
  logic                 dm_we_i;
  logic [ADDRWIDTH-1:0] dm_addr_i;
  logic [DATAWIDTH-1:0] dm_wdata_i;
  logic                 dm_gnt_o;
  logic                 dm_rvalid_o;
  logic [DATAWIDTH-1:0] dm_rdata_o;
  logic                 mem_req_o;
  logic                 mem_we_o;
  logic [ADDRWIDTH-1:0] mem_addr_o;
  logic [DATAWIDTH-1:0] mem_wdata_o;
  logic [DATAWIDTH-1:0] mem_rdata_i;
  logic                 busy_o;

  modport slave (
    input  if_req_i, if_addr_i,
    input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    input  mem_rdata_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    output dm_gnt_o, dm_rvalid_o, dm_rdata_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output busy_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    output mem_rdata_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    input  dm_gnt_o, dm_rvalid_o, dm_rdata_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  busy_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for one single-port memory, data-first with fetch starve guard.
// Ports: clk_i, rst_i (async active-low), bus (mem_arbiter_if.slave).
module mem_arbiter #(
  parameter int DATAWIDTH    = 32,
  parameter int ADDRWIDTH    = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  mem_arbiter_if.slave  bus
);

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [3:0]           starve_q, starve_d;
  logic                 owner_q, owner_d;
  logic                 we_q, we_d;
  logic                 if_rv_q, if_rv_d;
  logic                 dm_rv_q, dm_rv_d;
  logic [DATAWIDTH-1:0] if_rd_q, if_rd_d;
  logic [DATAWIDTH-1:0] dm_rd_q, dm_rd_d;

  logic                 if_gnt;
  logic                 dm_gnt;
  logic                 mem_req;
  logic                 mem_we;
  logic [ADDRWIDTH-1:0] mem_addr;
  logic [DATAWIDTH-1:0] mem_wdata;
  logic                 pick_dm;

  // Fetch overrides data only once it has been passed over enough times.
  assign pick_dm = bus.dm_req_i &
    !(bus.if_req_i && starve_q == 4'(STARVE_LIMIT));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    starve_d  = starve_q;
    owner_d   = owner_q;
    we_d      = we_q;
    if_rv_d   = 1'b0;
    dm_rv_d   = 1'b0;
    if_rd_d   = if_rd_q;
    dm_rd_d   = dm_rd_q;
    if_gnt    = 1'b0;
    dm_gnt    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      S_IDLE: begin
        if (!bus.if_req_i) starve_d = '0;
        if (pick_dm) begin
          dm_gnt    = 1'b1;
          mem_req   = 1'b1;
          mem_we    = bus.dm_we_i;
          mem_addr  = bus.dm_addr_i;
          mem_wdata = bus.dm_wdata_i;
          owner_d   = 1'b1;
          we_d      = bus.dm_we_i;
          state_d   = S_WAIT;
          cnt_d     = 4'd1;
          if (bus.if_req_i) starve_d = starve_q + 4'd1;
        end else if (bus.if_req_i) begin
          if_gnt   = 1'b1;
          mem_req  = 1'b1;
          mem_addr = bus.if_addr_i;
          owner_d  = 1'b0;
          we_d     = 1'b0;
          state_d  = S_WAIT;
          cnt_d    = 4'd1;
          starve_d = '0;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'(MEM_LATENCY)) begin
          state_d = S_IDLE;
          if (owner_q) begin
            dm_rv_d = 1'b1;
            dm_rd_d = we_q ? '0 : bus.mem_rdata_i;
          end else begin
            if_rv_d = 1'b1;
            if_rd_d = bus.mem_rdata_i;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      starve_q <= '0;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      if_rv_q  <= 1'b0;
      dm_rv_q  <= 1'b0;
      if_rd_q  <= '0;
      dm_rd_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      if_rv_q  <= if_rv_d;
      dm_rv_q  <= dm_rv_d;
      if_rd_q  <= if_rd_d;
      dm_rd_q  <= dm_rd_d;
    end
  end

  // Grant path is combinational from req; mask it so reset silences every output.
  assign bus.if_gnt_o    = if_gnt & rst_i;
  assign bus.dm_gnt_o    = dm_gnt & rst_i;
  assign bus.mem_req_o   = mem_req & rst_i;
  assign bus.mem_we_o    = mem_we & rst_i;
  assign bus.mem_addr_o  = rst_i ? mem_addr : '0;
  assign bus.mem_wdata_o = rst_i ? mem_wdata : '0;
  assign bus.if_rvalid_o = if_rv_q;
  assign bus.dm_rvalid_o = dm_rv_q;
  assign bus.if_rdata_o  = if_rd_q;
  assign bus.dm_rdata_o  = dm_rd_q;
  assign bus.busy_o      = (state_q == S_WAIT);

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level model.
// Memory side is emulated here; one DUT with MEM_LATENCY=3, STARVE_LIMIT=4.
module tb_mem_arbiter;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int LAT = 3;
  localparam int SL  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) bus();

  mem_arbiter #(
    .DATAWIDTH(DW),
    .ADDRWIDTH(AW),
    .MEM_LATENCY(LAT),
    .STARVE_LIMIT(SL)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .bus(bus)
  );

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Model: one access in flight; owner answered LAT+1 cycles after grant.
  int          cyc = 0;
  int          resp_at = 0;
  int          starve = 0;
  bit          pend = 0;
  bit          own_dm = 0;
  logic [31:0] pend_data = 0;
  logic [31:0] exp_ifd = 0;
  logic [31:0] exp_dmd = 0;
  logic [31:0] memarr [64];
  bit          last_ig, last_dg;

  task automatic step(input logic ir, input logic [31:0] ia,
                      input logic dr, input logic dw,
                      input logic [31:0] da, input logic [31:0] dwd);
    bit e_ig, e_dg, e_irv, e_drv, e_busy, idle;
    logic [31:0] e_addr, e_wd;
    bit e_we;
    bus.if_req_i   = ir;
    bus.if_addr_i  = ia;
    bus.dm_req_i   = dr;
    bus.dm_we_i    = dw;
    bus.dm_addr_i  = da;
    bus.dm_wdata_i = dwd;
    if (pend && cyc == resp_at - 1) bus.mem_rdata_i = pend_data;
    else bus.mem_rdata_i = $urandom;
    e_irv = 0;
    e_drv = 0;
    if (pend && cyc == resp_at) begin
      if (own_dm) begin e_drv = 1; exp_dmd = pend_data; end
      else begin e_irv = 1; exp_ifd = pend_data; end
      pend = 0;
    end
    e_busy = pend;
    idle   = !pend;
    e_dg = idle && dr && !(ir && starve == SL);
    e_ig = idle && ir && !e_dg;
    e_we = e_dg && dw;
    e_addr = e_dg ? da : (e_ig ? ia : 32'h0);
    e_wd = e_dg ? dwd : 32'h0;
    #1;
    chk("if_gnt", bus.if_gnt_o, e_ig);
    chk("dm_gnt", bus.dm_gnt_o, e_dg);
    chk("mem_req", bus.mem_req_o, e_ig | e_dg);
    chk("mem_we", bus.mem_we_o, e_we);
    chk("mem_addr", bus.mem_addr_o, e_addr);
    chk("mem_wdata", bus.mem_wdata_o, e_wd);
    chk("if_rvalid", bus.if_rvalid_o, e_irv);
    chk("dm_rvalid", bus.dm_rvalid_o, e_drv);
    chk("if_rdata", bus.if_rdata_o, exp_ifd);
    chk("dm_rdata", bus.dm_rdata_o, exp_dmd);
    chk("busy", bus.busy_o, e_busy);
    if (idle && !ir) starve = 0;
    if (e_dg && ir) starve++;
    if (e_ig) starve = 0;
    if (e_dg || e_ig) begin
      pend    = 1;
      own_dm  = e_dg;
      resp_at = cyc + LAT + 1;
      if (e_dg && dw) begin
        pend_data = 0;
        memarr[da[7:2]] = dwd;
      end else begin
        pend_data = memarr[e_addr[7:2]];
      end
    end
    last_ig = e_ig;
    last_dg = e_dg;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic model_reset();
    pend    = 0;
    starve  = 0;
    exp_ifd = 0;
    exp_dmd = 0;
  endtask

  logic [9:0]  gseq;
  int          gn;
  logic        ir, dr, dw;
  logic [31:0] ia, da, dwd;

  initial begin
    for (int i = 0; i < 64; i++) memarr[i] = $urandom;
    bus.if_req_i = 0; bus.if_addr_i = 0;
    bus.dm_req_i = 0; bus.dm_we_i = 0;
    bus.dm_addr_i = 0; bus.dm_wdata_i = 0;
    bus.mem_rdata_i = 0;
    #3;
    bus.if_req_i = 1;
    bus.dm_req_i = 1;
    #1;
    chk("rst_gnt", {bus.if_gnt_o, bus.dm_gnt_o, bus.mem_req_o}, 0);
    chk("rst_out", {bus.if_rvalid_o, bus.dm_rvalid_o, bus.busy_o}, 0);
    chk("rst_rdata", {bus.if_rdata_o, bus.dm_rdata_o}, 0);
    bus.if_req_i = 0;
    bus.dm_req_i = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;

    // fetch only
    memarr[0] = 32'hA5A5A5A5;
    step(1, 32'h100, 0, 0, 0, 0);
    for (int i = 0; i < LAT + 1; i++) step(0, 0, 0, 0, 0, 0);
    chk("t1_rdata", bus.if_rdata_o, 32'hA5A5A5A5);

    // store then load back
    step(0, 0, 1, 1, 32'h80, 32'hDEADBEEF);
    for (int i = 0; i < LAT; i++) step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 32'h80, 0);
    for (int i = 0; i < LAT + 1; i++) step(0, 0, 0, 0, 0, 0);
    chk("ld_back", bus.dm_rdata_o, 32'hDEADBEEF);

    // both held: starvation pattern, grant in same cycle as rvalid
    gseq = 0;
    gn = 0;
    for (int i = 0; i < 10 * (LAT + 1); i++) begin
      step(1, 32'h200 + i * 4, 1, 0, 32'h40, 0);
      if (last_ig || last_dg) begin
        gseq[gn] = last_ig;
        gn++;
      end
    end
    chk("starve_seq", gseq, 10'h210);
    chk("grant_rate", gn, 10);
    step(0, 0, 0, 0, 0, 0);

    // reset in the middle of a wait
    step(0, 0, 1, 0, 32'h44, 0);
    step(1, 32'h300, 1, 0, 32'h44, 0);
    #2;
    rst_n = 0;
    #1;
    chk("arst_gnt", {bus.if_gnt_o, bus.dm_gnt_o, bus.mem_req_o}, 0);
    chk("arst_busy", bus.busy_o, 0);
    chk("arst_rdata", {bus.if_rdata_o, bus.dm_rdata_o}, 0);
    model_reset();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < LAT + 2; i++) step(0, 0, 0, 0, 0, 0);

    // random traffic with hold-until-grant and occasional drops
    ir = 0; dr = 0; dw = 0; ia = 0; da = 0; dwd = 0;
    for (int n = 0; n < 600; n++) begin
      if (!ir || last_ig || ($urandom % 10 == 0)) begin
        ir = ($urandom % 3 != 0);
        ia = {$urandom} & 32'hFFFF_FFFC;
      end
      if (!dr || last_dg || ($urandom % 10 == 0)) begin
        dr  = ($urandom % 2 == 0);
        dw  = $urandom % 2;
        da  = {$urandom} & 32'h0000_00FC;
        dwd = $urandom;
      end
      step(ir, ia, dr, dw, da, dwd);
    end
    for (int i = 0; i < LAT + 2; i++) step(0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
